// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-tap FIR controller: datapath opcodes,
// state encodings and the register-file map.
package fir_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        COPY  = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        ADD   = 3'd4,
        SUB   = 3'd5,
        MUL   = 3'd6
    } op_t;

    typedef logic [4:0] state_t;

    localparam state_t IDLE   = 5'd0;
    localparam state_t LC0    = 5'd1;
    localparam state_t LC1    = 5'd2;
    localparam state_t LC2    = 5'd3;
    localparam state_t LC3    = 5'd4;
    localparam state_t STORE  = 5'd5;
    localparam state_t ZERO   = 5'd6;
    localparam state_t SHIFT1 = 5'd7;
    localparam state_t SHIFT2 = 5'd8;
    localparam state_t SHIFT3 = 5'd9;
    localparam state_t SHIFT4 = 5'd10;
    localparam state_t MUL1   = 5'd11;
    localparam state_t ADD1   = 5'd12;
    localparam state_t MUL2   = 5'd13;
    localparam state_t SUB2   = 5'd14;
    localparam state_t MUL3   = 5'd15;
    localparam state_t ADD3   = 5'd16;
    localparam state_t MUL4   = 5'd17;
    localparam state_t SUB4   = 5'd18;
    localparam state_t EIDLE  = 5'd19;

    localparam int unsigned R_RESULT  = 0;
    localparam int unsigned R_SAMPLE1 = 1;
    localparam int unsigned R_SAMPLE2 = 2;
    localparam int unsigned R_SAMPLE3 = 3;
    localparam int unsigned R_SAMPLE4 = 4;
    localparam int unsigned R_COEFF0  = 5;
    localparam int unsigned R_COEFF1  = 6;
    localparam int unsigned R_COEFF2  = 7;
    localparam int unsigned R_COEFF3  = 8;
    localparam int unsigned R_NEW     = 9;
    localparam int unsigned R_TEMP    = 10;

endpackage

// File: rtl/fir_sequencer_if.sv
// Control/status bundle between the FIR sequencer (master) and the
// datapath plus sample counter (slave).
interface fir_sequencer_if #(
    parameter int REG_W = 4
);
    logic              data_ready;
    logic              load_coeff;
    logic              overflow;
    logic              cnt_up;
    logic              clear;
    logic              modwait;
    logic              err;
    fir_pkg::op_t      op;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  dest;

    modport master (
        input  data_ready, load_coeff, overflow,
        output cnt_up, clear, modwait, err, op, src1, src2, dest
    );

    modport slave (
        output data_ready, load_coeff, overflow,
        input  cnt_up, clear, modwait, err, op, src1, src2, dest
    );
endinterface

// File: rtl/fir_sequencer.sv
// Control FSM for the 4-tap FIR: loads coefficients, then per sample steps the
// shared datapath through store, shift and multiply-accumulate.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int REG_W    = 4
) (
    input  logic            clk,
    input  logic            n_reset,
    fir_sequencer_if.master bus
);

    if (NUM_TAPS != 4) begin : g_taps_check
        $error("fir_sequencer: NUM_TAPS must be 4");
    end

    state_t            state;
    state_t            next;
    op_t               op;
    logic [REG_W-1:0]  s1;
    logic [REG_W-1:0]  s2;
    logic [REG_W-1:0]  d;
    logic              cnt_up;
    logic              clear;
    logic              modwait;
    logic              err;

    function automatic logic [REG_W-1:0] ridx(input int unsigned r);
        return REG_W'(r);
    endfunction

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = bus.load_coeff ? LC0 : (bus.data_ready ? STORE : IDLE);
            EIDLE:   next = bus.load_coeff ? LC0 : (bus.data_ready ? STORE : EIDLE);
            LC0:     next = bus.load_coeff ? LC1 : IDLE;
            LC1:     next = bus.load_coeff ? LC2 : IDLE;
            LC2:     next = bus.load_coeff ? LC3 : IDLE;
            LC3:     next = IDLE;
            STORE:   next = bus.data_ready ? ZERO : EIDLE;
            ZERO:    next = SHIFT1;
            SHIFT1:  next = SHIFT2;
            SHIFT2:  next = SHIFT3;
            SHIFT3:  next = SHIFT4;
            SHIFT4:  next = MUL1;
            MUL1:    next = ADD1;
            ADD1:    next = bus.overflow ? EIDLE : MUL2;
            MUL2:    next = SUB2;
            SUB2:    next = bus.overflow ? EIDLE : MUL3;
            MUL3:    next = ADD3;
            ADD3:    next = bus.overflow ? EIDLE : MUL4;
            MUL4:    next = SUB4;
            SUB4:    next = bus.overflow ? EIDLE : IDLE;
            default: next = IDLE;
        endcase
    end

    // Datapath controls follow the current state; the coefficient load and the
    // counter clear are additionally gated by load_coeff so a dropped load is a no-op.
    always_comb begin
        op     = NOP;
        s1     = '0;
        s2     = '0;
        d      = '0;
        cnt_up = 1'b0;
        clear  = 1'b0;
        case (state)
            IDLE, EIDLE: clear = bus.load_coeff;
            LC0: if (bus.load_coeff) begin op = LOAD2; d = ridx(R_COEFF0); end
            LC1: if (bus.load_coeff) begin op = LOAD2; d = ridx(R_COEFF1); end
            LC2: if (bus.load_coeff) begin op = LOAD2; d = ridx(R_COEFF2); end
            LC3: if (bus.load_coeff) begin op = LOAD2; d = ridx(R_COEFF3); end
            STORE: begin op = LOAD1; d = ridx(R_NEW); cnt_up = 1'b1; end
            ZERO: begin
                op = SUB; s1 = ridx(R_RESULT); s2 = ridx(R_RESULT); d = ridx(R_RESULT);
            end
            SHIFT1: begin op = COPY; s1 = ridx(R_SAMPLE3); d = ridx(R_SAMPLE4); end
            SHIFT2: begin op = COPY; s1 = ridx(R_SAMPLE2); d = ridx(R_SAMPLE3); end
            SHIFT3: begin op = COPY; s1 = ridx(R_SAMPLE1); d = ridx(R_SAMPLE2); end
            SHIFT4: begin op = COPY; s1 = ridx(R_NEW);     d = ridx(R_SAMPLE1); end
            MUL1: begin op = MUL; s1 = ridx(R_SAMPLE1); s2 = ridx(R_COEFF0); d = ridx(R_TEMP); end
            MUL2: begin op = MUL; s1 = ridx(R_SAMPLE2); s2 = ridx(R_COEFF1); d = ridx(R_TEMP); end
            MUL3: begin op = MUL; s1 = ridx(R_SAMPLE3); s2 = ridx(R_COEFF2); d = ridx(R_TEMP); end
            MUL4: begin op = MUL; s1 = ridx(R_SAMPLE4); s2 = ridx(R_COEFF3); d = ridx(R_TEMP); end
            ADD1, ADD3: begin
                op = ADD; s1 = ridx(R_RESULT); s2 = ridx(R_TEMP); d = ridx(R_RESULT);
            end
            SUB2, SUB4: begin
                op = SUB; s1 = ridx(R_RESULT); s2 = ridx(R_TEMP); d = ridx(R_RESULT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            modwait <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= next;
            modwait <= (next != IDLE) && (next != EIDLE);
            err     <= (next == EIDLE);
        end
    end

    assign bus.op      = op;
    assign bus.src1    = s1;
    assign bus.src2    = s2;
    assign bus.dest    = d;
    assign bus.cnt_up  = cnt_up;
    assign bus.clear   = clear;
    assign bus.modwait = modwait;
    assign bus.err     = err;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: drives a small register-file/ALU model from
// the sequencer outputs and compares every cycle against hand-derived vectors.
module tb_fir_sequencer;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic [7:0] din = '0;
    logic signed [15:0] rf [16];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fir_sequencer_if #(.REG_W(4)) bus ();

    fir_sequencer #(.NUM_TAPS(4), .REG_W(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Datapath model, written by the sequencer's op/src/dest.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (bus.op)
                LOAD1, LOAD2: rf[bus.dest] <= {8'b0, din};
                COPY:         rf[bus.dest] <= rf[bus.src1];
                ADD:          rf[bus.dest] <= rf[bus.src1] + rf[bus.src2];
                SUB:          rf[bus.dest] <= rf[bus.src1] - rf[bus.src2];
                MUL:          rf[bus.dest] <= rf[bus.src1] * rf[bus.src2];
                default: ;
            endcase
        end
    end

    op_t tbl_op [13] = '{SUB, COPY, COPY, COPY, COPY, MUL, ADD, MUL, SUB, MUL, ADD, MUL, SUB};
    int  tbl_s1 [13] = '{0, 3, 2, 1, 9, 1, 0, 2, 0, 3, 0, 4, 0};
    int  tbl_s2 [13] = '{0, 0, 0, 0, 0, 5, 10, 6, 10, 7, 10, 8, 10};
    int  tbl_d  [13] = '{0, 4, 3, 2, 1, 10, 0, 10, 0, 10, 0, 10, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'b0, bus.op, bus.src1, bus.src2, bus.dest,
                bus.cnt_up, bus.clear, bus.modwait, bus.err};
    endfunction

    function automatic logic [31:0] ev(input op_t o, input int s1, input int s2, input int d,
                                       input bit cu, input bit cl, input bit mw, input bit er);
        return {13'b0, o, 4'(s1), 4'(s2), 4'(d), cu, cl, mw, er};
    endfunction

    task automatic step(input logic dr, input logic lc, input logic ov, input logic [7:0] d);
        @(negedge clk);
        bus.data_ready = dr;
        bus.load_coeff = lc;
        bus.overflow   = ov;
        din            = d;
        #1;
    endtask

    // One sample from IDLE/EIDLE through the MAC sequence; ov_at aborts at that table index.
    task automatic run_sequence(input string tag, input logic [7:0] sample, input int ov_at,
                                input bit from_err, input bit ov_mul);
        int unsigned busy;
        bit ov;
        busy = 0;
        step(1'b1, 1'b0, 1'b0, 8'd0);
        check({tag, "_pre"}, outs(), ev(NOP, 0, 0, 0, 0, 0, 0, from_err));
        step(1'b1, 1'b0, 1'b0, sample);
        check({tag, "_store"}, outs(), ev(LOAD1, 0, 0, 9, 1, 0, 1, 0));
        busy += 32'(bus.modwait);
        for (int i = 0; i < 13; i++) begin
            ov = (i == ov_at) || (ov_mul && tbl_op[i] == MUL);
            step(1'b0, 1'b0, ov, 8'd0);
            check($sformatf("%s_s%0d", tag, i), outs(),
                  ev(tbl_op[i], tbl_s1[i], tbl_s2[i], tbl_d[i], 0, 0, 1, 0));
            busy += 32'(bus.modwait);
            if (i == ov_at) begin
                step(1'b0, 1'b0, 1'b0, 8'd0);
                check({tag, "_eidle"}, outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 1));
                return;
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check({tag, "_idle"}, outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        check({tag, "_busy"}, busy, 32'd14);
    endtask

    initial begin
        bus.data_ready = 1'b0;
        bus.load_coeff = 1'b0;
        bus.overflow   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            check($sformatf("idle%0d", i), outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        end

        // Coefficients F0..F3 = 1,2,3,4
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("lc_clear", outs(), ev(NOP, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'(k + 1));
            check($sformatf("lc%0d", k), outs(), ev(LOAD2, 0, 0, 5 + k, 0, 0, 1, 0));
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("lc_done", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));

        // R0 = 10*1
        run_sequence("smp10", 8'd10, -1, 1'b0, 1'b0);
        check("r0_smp10", {16'b0, rf[0]}, 32'd10);

        run_sequence("ovf", 8'd20, 8, 1'b0, 1'b0);

        // Samples 5,20,10,0: R0 = 5 - 40 + 30 - 0 = -5; overflow during MULs ignored
        run_sequence("recov", 8'd5, -1, 1'b1, 1'b1);
        check("r0_recov", {16'b0, rf[0]}, 32'h0000_FFFB);

        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("drop_pre", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 8'd7);
        check("drop_store", outs(), ev(LOAD1, 0, 0, 9, 1, 0, 1, 0));
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("drop_eidle", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 1));
        // Samples 3,5,20,10: R0 = 3 - 10 + 60 - 40 = 13
        run_sequence("after_drop", 8'd3, -1, 1'b1, 1'b0);
        check("r0_after_drop", {16'b0, rf[0]}, 32'd13);

        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("mid_shift1", outs(), ev(COPY, 3, 0, 4, 0, 0, 1, 0));
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("mid_reset", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        check("mid_release", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("mid_idle", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));

        // load_coeff beats data_ready; load dropped in LC2
        step(1'b1, 1'b1, 1'b0, 8'd0);
        check("pri_idle", outs(), ev(NOP, 0, 0, 0, 0, 1, 0, 0));
        step(1'b1, 1'b1, 1'b0, 8'd9);
        check("pri_lc0", outs(), ev(LOAD2, 0, 0, 5, 0, 0, 1, 0));
        step(1'b1, 1'b1, 1'b0, 8'd9);
        check("pri_lc1", outs(), ev(LOAD2, 0, 0, 6, 0, 0, 1, 0));
        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("pri_lc2_drop", outs(), ev(NOP, 0, 0, 0, 0, 0, 1, 0));
        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("pri_back_idle", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b0, 8'd4);
        check("pri_store", outs(), ev(LOAD1, 0, 0, 9, 1, 0, 1, 0));
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("pri_end", outs(), ev(NOP, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
